// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback pipe, late load return and register-file write port bundle.
interface rf_wb_arbiter_if;
  logic        pipe_valid;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  modport slave (
    input  pipe_valid, pipe_we, pipe_rd, pipe_data, mem_valid, mem_rd, mem_data,
    output pipe_stall, mem_ready, rf_we, rf_rd, rf_wd
  );
  modport master (
    output pipe_valid, pipe_we, pipe_rd, pipe_data, mem_valid, mem_rd, mem_data,
    input  pipe_stall, mem_ready, rf_we, rf_rd, rf_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between the in-order WB stage
// and a 2-deep buffer of late load returns, with anti-starvation forcing.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst_n,
  rf_wb_arbiter_if.slave  bus
);
  typedef enum logic {NORMAL, FORCE} state_e;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d, pos;
  logic [3:0]  wait_q, wait_d;
  logic [4:0]  hd_rd_q, hd_rd_d, tl_rd_q, tl_rd_d;
  logic [31:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        stall, pipe_req, grant_head, enq;
  assign stall      = (state_q == FORCE) | (cnt_q == 2'd2);
  assign pipe_req   = bus.pipe_valid & bus.pipe_we & (bus.pipe_rd != 5'd0) & ~stall;
  assign grant_head = (cnt_q != 2'd0) & ~pipe_req;
  assign enq        = bus.mem_valid & (cnt_q != 2'd2) & (bus.mem_rd != 5'd0);
  // slot for a new return is computed after the head has shifted out
  assign pos        = cnt_q - {1'b0, grant_head};
  always_comb begin
    hd_rd_d   = (enq & pos == 2'd0) ? bus.mem_rd   : grant_head ? tl_rd_q   : hd_rd_q;
    hd_data_d = (enq & pos == 2'd0) ? bus.mem_data : grant_head ? tl_data_q : hd_data_q;
    tl_rd_d   = (enq & pos == 2'd1) ? bus.mem_rd   : tl_rd_q;
    tl_data_d = (enq & pos == 2'd1) ? bus.mem_data : tl_data_q;
    cnt_d     = cnt_q + {1'b0, enq} - {1'b0, grant_head};
    wait_d    = (cnt_q == 2'd0 | grant_head) ? 4'd0 : (wait_q == LIM) ? wait_q : wait_q + 4'd1;
    state_d   = (state_q == NORMAL) ? ((wait_d == LIM) ? FORCE : NORMAL)
                                    : ((cnt_d == 2'd0) ? NORMAL : FORCE);
    rf_we_d   = grant_head | pipe_req;
    rf_rd_d   = grant_head ? hd_rd_q   : pipe_req ? bus.pipe_rd   : rf_rd_q;
    rf_wd_d   = grant_head ? hd_data_q : pipe_req ? bus.pipe_data : rf_wd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      cnt_q     <= 2'd0;
      wait_q    <= 4'd0;
      hd_rd_q   <= 5'd0;
      hd_data_q <= 32'd0;
      tl_rd_q   <= 5'd0;
      tl_data_q <= 32'd0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_wd_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      hd_rd_q   <= hd_rd_d;
      hd_data_q <= hd_data_d;
      tl_rd_q   <= tl_rd_d;
      tl_data_q <= tl_data_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_wd_q   <= rf_wd_d;
    end
  end
  assign bus.pipe_stall = stall;
  assign bus.mem_ready  = cnt_q != 2'd2;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wd      = rf_wd_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic checked against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int LIM = 4;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  ent_t q[$];
  bit frc;
  int wt;
  logic m_we;
  logic [4:0] m_rd;
  logic [31:0] m_wd;
  rf_wb_arbiter_if bus();
  rf_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    frc = 0;
    wt = 0;
    m_we = 0;
    m_rd = 0;
    m_wd = 0;
  endtask
  task automatic drv(input bit pv, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                     input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.pipe_valid = pv;
    bus.pipe_we = pw;
    bus.pipe_rd = prd;
    bus.pipe_data = pd;
    bus.mem_valid = mv;
    bus.mem_rd = mrd;
    bus.mem_data = md;
  endtask
  task automatic step();
    bit stall, preq, gh;
    int n0;
    ent_t e;
    #1;
    n0 = q.size();
    stall = frc || n0 == 2;
    check("pipe_stall", 32'(bus.pipe_stall), 32'(stall));
    check("mem_ready", 32'(bus.mem_ready), 32'(n0 < 2));
    preq = bus.pipe_valid && bus.pipe_we && bus.pipe_rd != 0 && !stall;
    gh = n0 > 0 && !preq;
    if (gh) begin
      e = q.pop_front();
      m_we = 1; m_rd = e.rd; m_wd = e.d;
    end else if (preq) begin
      m_we = 1; m_rd = bus.pipe_rd; m_wd = bus.pipe_data;
    end else m_we = 0;
    wt = (n0 == 0 || gh) ? 0 : (wt < LIM ? wt + 1 : wt);
    if (bus.mem_valid && n0 < 2 && bus.mem_rd != 0) begin
      e.rd = bus.mem_rd; e.d = bus.mem_data;
      q.push_back(e);
    end
    frc = frc ? q.size() != 0 : wt == LIM;
    @(posedge clk);
    #1;
    check("rf_we", 32'(bus.rf_we), 32'(m_we));
    check("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
    check("rf_wd", bus.rf_wd, m_wd);
  endtask
  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rf_we", 32'(bus.rf_we), 0);
    check("rst_rf_rd", 32'(bus.rf_rd), 0);
    check("rst_rf_wd", bus.rf_wd, 0);
    check("rst_ready", 32'(bus.mem_ready), 1);
    check("rst_stall", 32'(bus.pipe_stall), 0);
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("init_rf_we", 32'(bus.rf_we), 0);
    check("init_ready", 32'(bus.mem_ready), 1);
    check("init_stall", 32'(bus.pipe_stall), 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    // pipe write visible next cycle; rd=0 produces nothing
    drv(1, 1, 5, 32'hDEADBEEF, 0, 0, 0); step();
    check("p31_we", 32'(bus.rf_we), 1);
    check("p31_rd", 32'(bus.rf_rd), 5);
    check("p31_wd", bus.rf_wd, 32'hDEADBEEF);
    drv(1, 1, 0, 32'h11111111, 0, 0, 0); step();
    check("p31_rd0_we", 32'(bus.rf_we), 0);
    // load return visible two cycles after acceptance
    drv(0, 0, 0, 0, 1, 7, 32'h1234); step();
    check("m32_n1_we", 32'(bus.rf_we), 0);
    drv(0, 0, 0, 0, 0, 0, 0); step();
    check("m32_n2_we", 32'(bus.rf_we), 1);
    check("m32_n2_rd", 32'(bus.rf_rd), 7);
    check("m32_n2_wd", bus.rf_wd, 32'h1234);
    step();
    check("m32_n3_we", 32'(bus.rf_we), 0);
    // fill the buffer under continuous pipe writes
    drv(1, 1, 10, 32'hA0, 1, 3, 32'h33); step();
    drv(1, 1, 10, 32'hA1, 1, 4, 32'h44); step();
    check("f33_ready", 32'(bus.mem_ready), 0);
    check("f33_stall", 32'(bus.pipe_stall), 1);
    drv(1, 1, 10, 32'hA1, 0, 0, 0); step();
    check("f33_first", 32'(bus.rf_rd), 3);
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, 10, 32'hB0 + i, 0, 0, 0); step();
    end
    idle(3);
    // starvation: pipe wins LIM cycles, then forced drain
    drv(1, 1, 11, 32'hC0, 1, 9, 32'h99); step();
    for (int i = 0; i < LIM; i++) begin
      drv(1, 1, 11, 32'hC1 + i, 0, 0, 0); step();
      check("s34_pipe_rd", 32'(bus.rf_rd), 11);
    end
    check("s34_force_stall", 32'(bus.pipe_stall), 1);
    step();
    check("s34_drain_rd", 32'(bus.rf_rd), 9);
    check("s34_released", 32'(bus.pipe_stall), 0);
    idle(2);
    // simultaneous enqueue and dequeue keep order
    drv(0, 0, 0, 0, 1, 12, 32'hC12); step();
    drv(0, 0, 0, 0, 1, 13, 32'hC13); step();
    check("o35_first", 32'(bus.rf_rd), 12);
    check("o35_ready", 32'(bus.mem_ready), 1);
    drv(0, 0, 0, 0, 0, 0, 0); step();
    check("o35_second", 32'(bus.rf_rd), 13);
    // reset with buffer full and forcing active
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 14, 32'hE0 + i, 1, 5'(20 + i), 32'hF0 + i); step();
    end
    mid_reset();
    check("r30_after_we", 32'(bus.rf_we), 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) mid_reset();
      drv($urandom_range(9) < 7, $urandom_range(9) < 8, 5'($urandom_range(31)), $urandom,
          $urandom_range(9) < 4, 5'($urandom_range(31)), $urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
